// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN_DEFAULT : default datapath/address width
//   NOP_INSTR    : addi x0, x0, 0, presented to decode when no instruction is ready
//   fetch_state_e: request FSM states
//   fetch_entry_t: prefetch FIFO entry (pc + instruction word)
package if_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic {
    StIdle,
    StWait
  } fetch_state_e;

  // The pc field is XLEN_DEFAULT wide; the fetch unit's XLEN must match it.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO holding fetched {pc, instr} entries for the decode stage.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : drop all entries; overrides push and pop in the same cycle
//   push, push_data  : write one entry (ignored when full)
//   pop              : remove the head entry (ignored when empty)
//   head             : current head entry, read from registered storage
//   count/full/empty : occupancy
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time over a
// req/ack handshake and buffers returned words for decode.
//   clk, rst                    : clock, synchronous active-high reset
//   stallf                      : decode not accepting; head is held
//   redirect_valid, redirect_pc : taken branch/jump from EX; flushes and retargets
//   imem_req, imem_addr         : fetch request, held with a stable address until ack
//   imem_ack, imem_rdata        : one-cycle response pulse with the fetched word
//   instr_valid, instr_out      : head of prefetch FIFO (NOP when empty)
//   pc_out, pc_plus4_out        : PC of head (0 when empty) and PC+4
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallf,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            drop_q, drop_d;
  logic            push, pop;
  fetch_entry_t    push_entry, head;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only issue when the returning word is guaranteed a free slot.
        if (!redirect_valid && !full) begin
          state_d    = StWait;
          req_addr_d = fetch_pc_q;
        end
      end
      StWait: begin
        if (imem_ack) begin
          state_d = StIdle;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_valid) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end
        end else if (redirect_valid) begin
          // Cannot withdraw the request; mark its word for discard instead.
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (redirect_valid) fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

  assign push_entry = '{pc: req_addr_q, instr: imem_rdata};
  assign pop        = instr_valid && !stallf && !redirect_valid;

  if_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign imem_req     = (state_q == StWait);
  assign imem_addr    = req_addr_q;
  assign instr_valid  = !empty;
  assign instr_out    = empty ? NOP_INSTR : head.instr;
  assign pc_out       = empty ? '0 : head.pc;
  assign pc_plus4_out = pc_out + XLEN'(4);

  count_in_range: assert property (@(posedge clk) disable iff (rst) count <= CntW'(DEPTH));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a variable-latency memory model, expected request addresses
// and expected pops queued by the stimulus, and a monitor that compares on each event.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stallf;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;

  int          checks;
  int          errors;
  int          pop_cnt;
  int unsigned mem_lat;
  logic        mem_hold;
  int unsigned ack_cnt;
  logic        mem_busy;
  int unsigned mem_wcnt;
  logic        req_prev;
  logic [31:0] held_addr;
  logic [31:0] e_addr;
  logic [31:0] e_pc;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_pc_q [$];

  if_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0080),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallf        (stallf),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .pc_plus4_out  (pc_plus4_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Memory: acks mem_lat cycles after it first sees a request; mem_hold withholds acks.
  always @(posedge clk) begin
    imem_ack <= 1'b0;
    if (rst) begin
      mem_busy <= 1'b0;
    end else if (mem_busy) begin
      if (mem_wcnt <= 1) begin
        imem_ack   <= 1'b1;
        imem_rdata <= instr_of(imem_addr);
        mem_busy   <= 1'b0;
        ack_cnt    <= ack_cnt + 1;
      end else begin
        mem_wcnt <= mem_wcnt - 1;
      end
    end else if (imem_req && !imem_ack && !mem_hold) begin
      if (mem_lat <= 1) begin
        imem_ack   <= 1'b1;
        imem_rdata <= instr_of(imem_addr);
        ack_cnt    <= ack_cnt + 1;
      end else begin
        mem_busy <= 1'b1;
        mem_wcnt <= mem_lat - 1;
      end
    end
  end

  // Monitor: new requests and pops are checked against the queued expectations.
  always @(negedge clk) begin
    if (imem_req === 1'b1 && req_prev !== 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL req_addr: unexpected request addr=%h", imem_addr);
      end else begin
        e_addr = exp_addr_q.pop_front();
        if (imem_addr !== e_addr) begin
          errors++;
          $display("FAIL req_addr: got %h expected %h", imem_addr, e_addr);
        end
      end
      held_addr = imem_addr;
    end else if (imem_req === 1'b1) begin
      checks++;
      if (imem_addr !== held_addr) begin
        errors++;
        $display("FAIL addr_stable: got %h expected %h", imem_addr, held_addr);
      end
    end
    req_prev = imem_req;
    if (!rst && instr_valid === 1'b1 && !stallf && !redirect_valid) begin
      checks++;
      pop_cnt++;
      if (exp_pc_q.size() == 0) begin
        errors++;
        $display("FAIL pop: unexpected pop pc=%h", pc_out);
      end else begin
        e_pc = exp_pc_q.pop_front();
        if (pc_out !== e_pc || instr_out !== instr_of(e_pc) || pc_plus4_out !== e_pc + 32'd4) begin
          errors++;
          $display("FAIL pop: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                   pc_out, instr_out, pc_plus4_out, e_pc, instr_of(e_pc), e_pc + 32'd4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n;
    n = 0;
    while (pop_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("pop_wait", 32'(pop_cnt), 32'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0; pop_cnt = 0; ack_cnt = 0;
    mem_lat = 1; mem_hold = 1'b0; mem_busy = 1'b0; mem_wcnt = 0;
    imem_ack = 1'b0; imem_rdata = '0; req_prev = 1'b0; held_addr = '0;
    rst = 1'b1; stallf = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h4);

    // Free-running 1-cycle memory: 0x80, 0x84, 0x88 flow through; 0x8C is in flight at reset.
    exp_addr_q.push_back(32'h80); exp_addr_q.push_back(32'h84);
    exp_addr_q.push_back(32'h88); exp_addr_q.push_back(32'h8C);
    exp_pc_q.push_back(32'h80); exp_pc_q.push_back(32'h84); exp_pc_q.push_back(32'h88);
    rst = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    chk("first_req", 32'(imem_req), 32'd1);
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    chk("fetch_to_valid", 32'(n), 32'd2);
    wait_pops(3, 40);

    // Stalled from reset: exactly two fetches, then the request line stays low.
    rst = 1'b1; stallf = 1'b1;
    tick(); tick();
    exp_addr_q.push_back(32'h80); exp_addr_q.push_back(32'h84);
    n = int'(ack_cnt);
    rst = 1'b0;
    repeat (12) tick();
    chk("stall_acks", 32'(int'(ack_cnt) - n), 32'd2);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_pc", pc_out, 32'h80);
    chk("stall_instr", instr_out, instr_of(32'h80));

    // Release stall, then redirect to 0x200 while 0x88 waits on a 5-cycle memory.
    mem_lat = 5;
    exp_pc_q.push_back(32'h80); exp_pc_q.push_back(32'h84); exp_pc_q.push_back(32'h200);
    exp_addr_q.push_back(32'h88); exp_addr_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204); exp_addr_q.push_back(32'h208);
    stallf = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("drop_req_held", 32'(imem_req), 32'd1);
    chk("drop_addr_held", imem_addr, 32'h88);
    wait_pops(6, 60);
    stallf = 1'b1;
    repeat (40) tick();
    chk("full_pc", pc_out, 32'h204);
    chk("full_req", 32'(imem_req), 32'd0);

    // Redirect to an unaligned target while full and stalled.
    mem_lat = 1;
    exp_addr_q.push_back(32'h100); exp_addr_q.push_back(32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_instr", instr_out, NOP);
    repeat (12) tick();
    chk("refill_pc", pc_out, 32'h100);

    // Redirect on the same edge as an ack and a pop.
    exp_pc_q.push_back(32'h100);
    exp_addr_q.push_back(32'h108); exp_addr_q.push_back(32'h300);
    stallf = 1'b0;
    tick();
    stallf = 1'b1;
    n = 0;
    while (!imem_ack && n < 10) begin tick(); n++; end
    chk("ack_seen", 32'(imem_ack), 32'd1);
    stallf = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0; stallf = 1'b1; mem_hold = 1'b1;
    chk("coinc_valid", 32'(instr_valid), 32'd0);
    repeat (4) tick();
    chk("coinc_req", 32'(imem_req), 32'd1);
    chk("coinc_addr", imem_addr, 32'h300);

    // Reset while a request is outstanding.
    rst = 1'b1;
    tick();
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr_out, NOP);
    chk("midrst_pc4", pc_plus4_out, 32'h4);
    tick();
    mem_hold = 1'b0;
    exp_addr_q.push_back(32'h80); exp_addr_q.push_back(32'h84);
    rst = 1'b0;
    repeat (12) tick();
    chk("post_rst_pc", pc_out, 32'h80);
    chk("post_rst_pc4", pc_plus4_out, 32'h84);

    // PC wraps past the top of the address space.
    exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_out, 32'h0);
    chk("wrap_instr", instr_out, instr_of(32'hFFFF_FFFC));
    chk("wrap_req", 32'(imem_req), 32'd0);

    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("pop_q_drained", 32'(exp_pc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end. Drives the instruction memory and feeds the IF/ID register of the 5-stage RISC-V pipeline.
- Owns the PC register and issues one word-aligned fetch request at a time over a req/ack handshake, so memory latency is variable.
- Buffers returned words in a small prefetch FIFO.
- Honours stall and redirect (branch/jump resolved in EX) from the hazard unit.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stallf  in  1  decode stage not accepting; no FIFO pop.
- redirect_valid  in  1  taken branch/jump/jalr resolved in EX.
- redirect_pc  in  XLEN  redirect target.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  XLEN  word-aligned fetch address, stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse: imem_rdata valid.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_out  out  32  FIFO head instruction; NOP (32'h0000_0013) when empty.
- pc_out  out  XLEN  PC of head instruction.
- pc_plus4_out  out  XLEN  pc_out+4, modulo 2^XLEN.

Behaviour:
- Reset (clk edge with rst=1):
  - fetch_pc=RESET_PC; FIFO empty; FSM=IDLE; drop flag=0.
  - imem_req=0, instr_valid=0, instr_out=NOP, pc_out=0, pc_plus4_out=4.
- FSM states:
  - IDLE: if count<DEPTH and no redirect this cycle, go to WAIT and raise imem_req with imem_addr=fetch_pc next cycle. First request appears the cycle after rst falls.
  - WAIT: imem_req=1. On imem_ack:
    - if drop=0, push {fetch_pc, imem_rdata} and fetch_pc+=4;
    - if drop=1, discard the word and clear drop.
    - Then return to IDLE. imem_req is low for at least one cycle between requests.
- Ack is only valid in WAIT. imem_ack in IDLE is ignored.
- Pop: on an edge with instr_valid=1 and stallf=0, the head is removed.
- Push and pop in the same cycle: count unchanged.
- FIFO full (count=DEPTH): no new request. A request in flight is only issued when count+1≤DEPTH, so an ack can never overflow the FIFO.
- Output timing: outputs come from registered FIFO head. instr_valid rises the cycle after the ack edge. Minimum fetch-to-issue latency is 2 cycles.
- Redirect (highest priority):
  - flush the FIFO (instr_valid=0 next cycle);
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00};
  - any pop or push that cycle is cancelled.
- Redirect while in WAIT without ack: set drop=1; imem_req stays high with the old address until ack, which is then discarded.
- Redirect coinciding with imem_ack: word discarded, drop stays 0, FSM goes to IDLE.
- Stall and redirect together: redirect wins.
- fetch_pc wraps modulo 2^XLEN (32'hFFFF_FFFC+4 → 0).
- rst mid-WAIT: request abandoned, imem_req=0 next cycle. The instruction memory is reset by the same rst.

Decomposition:
- Shared package if_pkg:
  - XLEN default;
  - NOP_INSTR=32'h0000_0013;
  - fetch state enum {IDLE, WAIT};
  - FIFO entry typedef {pc, instr}.
- Sub-module: if_prefetch_fifo (DEPTH entries; push/pop/flush; count, full, empty; head outputs).
- FSM, PC register and drop flag live in if_fetch_unit.

Test Plan:
- Reset then 1-cycle-latency memory, stallf=0 → addresses 0,4,8 requested. instr_valid first rises 2 cycles after first imem_req; pc_out sequence 0,4,8.
- stallf=1 held 10 cycles, DEPTH=2 → exactly 2 acks accepted, then imem_req stays 0. instr_out/pc_out frozen at pc 0. Release stall → pops resume in order 0,4.
- Redirect_valid with redirect_pc=32'h0000_0103 while FIFO holds 2 entries → instr_valid=0 next cycle; next imem_addr=32'h100.
- Redirect to 32'h200 during a 5-cycle memory wait on addr 32'h8 → imem_req held on 32'h8 until ack; word discarded; next request 32'h200; first valid pc_out=32'h200.
- Redirect on the same edge as imem_ack and a pop → FIFO empty, no push; next address = redirect target.
- rst asserted mid-WAIT with RESET_PC=32'h80 → imem_req=0, instr_valid=0, instr_out=NOP next cycle. After release, first imem_addr=32'h80.
